// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of the CPU fetch/data channels and the shared memory port.
// Valid/ready: a beat transfers on a rising clk edge where both are high; a raised valid and its payload stay stable until that edge.
interface cpu_mem_arbiter_if;
   logic [31:0] PC;
   logic        Inst_Req_Valid;
   logic        Inst_Req_Ready;
   logic [31:0] Instruction;
   logic        Inst_Valid;
   logic        Inst_Ready;
   logic [31:0] Address;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic        MemRead;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_ready;

   // Arbiter view.
   modport slave (
      input  PC, Inst_Req_Valid, Inst_Ready,
      input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output Inst_Req_Ready, Instruction, Inst_Valid,
      output Mem_Req_Ready, Read_data, Read_data_Valid,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
      output mem_resp_ready
   );

   // CPU plus memory view.
   modport master (
      output PC, Inst_Req_Valid, Inst_Ready,
      output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  Inst_Req_Ready, Instruction, Inst_Valid,
      input  Mem_Req_Ready, Read_data, Read_data_Valid,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
      input  mem_resp_ready
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Serialises CPU fetch and data requests onto one memory port, one transaction
// in flight, and returns read data on the channel that issued the request.
module cpu_mem_arbiter #(
   parameter bit DATA_PRIO = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   cpu_mem_arbiter_if.slave bus,
   output logic [31:0]      conflict_cnt,
   output logic [1:0]       fsm_state
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state;
   logic   src_data;
   logic   data_req;
   logic   both_req;
   logic   grant_data;
   logic   grant_inst;

   // A simultaneous read+write is issued as a write.
   assign data_req   = bus.MemRead | bus.MemWrite;
   assign both_req   = data_req & bus.Inst_Req_Valid;
   assign grant_data = (state == IDLE) & data_req & (~bus.Inst_Req_Valid | DATA_PRIO);
   assign grant_inst = (state == IDLE) & bus.Inst_Req_Valid & (~data_req | ~DATA_PRIO);

   assign bus.Mem_Req_Ready  = grant_data;
   assign bus.Inst_Req_Ready = grant_inst;
   assign fsm_state          = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         src_data            <= 1'b0;
         conflict_cnt        <= 32'd0;
         bus.mem_req_valid   <= 1'b0;
         bus.mem_req_addr    <= 32'd0;
         bus.mem_req_wen     <= 1'b0;
         bus.mem_req_wdata   <= 32'd0;
         bus.mem_req_wstrb   <= 4'd0;
         bus.mem_resp_ready  <= 1'b0;
         bus.Instruction     <= 32'd0;
         bus.Inst_Valid      <= 1'b0;
         bus.Read_data       <= 32'd0;
         bus.Read_data_Valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (both_req) conflict_cnt <= conflict_cnt + 32'd1;
               if (grant_data) begin
                  src_data          <= 1'b1;
                  bus.mem_req_addr  <= bus.Address;
                  bus.mem_req_wen   <= bus.MemWrite;
                  bus.mem_req_wdata <= bus.MemWrite ? bus.Write_data : 32'd0;
                  bus.mem_req_wstrb <= bus.MemWrite ? bus.Write_strb : 4'd0;
                  bus.mem_req_valid <= 1'b1;
                  state             <= REQ;
               end else if (grant_inst) begin
                  src_data          <= 1'b0;
                  bus.mem_req_addr  <= bus.PC;
                  bus.mem_req_wen   <= 1'b0;
                  bus.mem_req_wdata <= 32'd0;
                  bus.mem_req_wstrb <= 4'd0;
                  bus.mem_req_valid <= 1'b1;
                  state             <= REQ;
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  bus.mem_req_valid <= 1'b0;
                  // Writes complete at the request handshake; nothing returns to the CPU.
                  if (bus.mem_req_wen) begin
                     state <= IDLE;
                  end else begin
                     bus.mem_resp_ready <= 1'b1;
                     state              <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.mem_resp_valid) begin
                  bus.mem_resp_ready <= 1'b0;
                  if (src_data) begin
                     bus.Read_data       <= bus.mem_resp_data;
                     bus.Read_data_Valid <= 1'b1;
                  end else begin
                     bus.Instruction <= bus.mem_resp_data;
                     bus.Inst_Valid  <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               if (src_data && bus.Read_data_Ready) begin
                  bus.Read_data_Valid <= 1'b0;
                  state               <= IDLE;
               end else if (!src_data && bus.Inst_Ready) begin
                  bus.Inst_Valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: stimulus pushes expected memory beats and
// CPU responses into queues, a monitor pops and compares on every handshake.
module tb_cpu_mem_arbiter;
   logic        clk;
   logic        rst;
   logic [31:0] conflict_cnt;
   logic [1:0]  fsm_state;

   cpu_mem_arbiter_if bus ();

   cpu_mem_arbiter #(.DATA_PRIO(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .conflict_cnt (conflict_cnt),
      .fsm_state    (fsm_state)
   );

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   int checks = 0;
   int errors = 0;
   int mem_hs = 0;
   int inst_hs = 0;
   int rd_hs = 0;

   logic [68:0] exp_req_q[$];
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_rd_q[$];

   bit auto_mem  = 1'b1;
   int req_stall = 0;
   int rd_hold   = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_lookup(input logic [31:0] a);
      case (a)
         32'h0000_0100: mem_lookup = 32'h3C08_0001;
         32'h0000_0200: mem_lookup = 32'h0000_AAAA;
         32'h0000_3000: mem_lookup = 32'h1122_3344;
         32'h0000_3004: mem_lookup = 32'hCAFE_F00D;
         default:       mem_lookup = 32'hBAD0_BAD0;
      endcase
   endfunction

   // ---------------- memory responder ----------------
   initial begin
      logic [31:0] pend_addr;
      logic        pend_wen;
      bit          pend;
      int          stall;
      pend = 1'b0; stall = 0; pend_addr = '0; pend_wen = 1'b0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (auto_mem) begin
            if (rst) begin
               bus.mem_req_ready  = 1'b0;
               bus.mem_resp_valid = 1'b0;
               pend = 1'b0; stall = 0;
            end else begin
               if (bus.mem_req_ready) begin
                  bus.mem_req_ready = 1'b0;
                  pend  = !pend_wen;
                  stall = 0;
               end else if (bus.mem_req_valid) begin
                  if (stall >= req_stall) begin
                     bus.mem_req_ready = 1'b1;
                     pend_addr = bus.mem_req_addr;
                     pend_wen  = bus.mem_req_wen;
                  end else begin
                     stall++;
                  end
               end
               if (bus.mem_resp_valid) begin
                  bus.mem_resp_valid = 1'b0;
               end else if (pend && bus.mem_resp_ready) begin
                  bus.mem_resp_valid = 1'b1;
                  bus.mem_resp_data  = mem_lookup(pend_addr);
                  pend = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- CPU response sink ----------------
   initial begin
      int rh;
      rh = 0;
      bus.Inst_Ready      = 1'b0;
      bus.Read_data_Ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.Inst_Ready      = 1'b0;
            bus.Read_data_Ready = 1'b0;
            rh = 0;
         end else begin
            if (bus.Inst_Ready) bus.Inst_Ready = 1'b0;
            else if (bus.Inst_Valid) bus.Inst_Ready = 1'b1;
            if (bus.Read_data_Ready) begin
               bus.Read_data_Ready = 1'b0;
            end else if (bus.Read_data_Valid) begin
               if (rh < rd_hold) rh++;
               else begin
                  bus.Read_data_Ready = 1'b1;
                  rh = 0;
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [68:0] cur_req, held_req, exp_req;
      logic [31:0] held_inst, held_rd, exp_w;
      bit held_req_v, held_inst_v, held_rd_v;
      held_req_v = 1'b0; held_inst_v = 1'b0; held_rd_v = 1'b0;
      held_req = '0; held_inst = '0; held_rd = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            held_req_v = 1'b0; held_inst_v = 1'b0; held_rd_v = 1'b0;
         end else begin
            cur_req = {bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb};
            if (held_req_v) begin
               chk("req_hold_valid", 69'(bus.mem_req_valid), 69'd1);
               chk("req_hold_fields", cur_req, held_req);
            end
            if (held_inst_v) begin
               chk("inst_hold_valid", 69'(bus.Inst_Valid), 69'd1);
               chk("inst_hold_data", 69'(bus.Instruction), 69'(held_inst));
            end
            if (held_rd_v) begin
               chk("rd_hold_valid", 69'(bus.Read_data_Valid), 69'd1);
               chk("rd_hold_data", 69'(bus.Read_data), 69'(held_rd));
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               mem_hs++;
               if (exp_req_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL req_unexpected actual=%0h required=none", cur_req);
               end else begin
                  exp_req = exp_req_q.pop_front();
                  chk("req_beat", cur_req, exp_req);
               end
            end
            if (bus.Inst_Valid && bus.Inst_Ready) begin
               inst_hs++;
               if (exp_inst_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL inst_unexpected actual=%0h required=none", bus.Instruction);
               end else begin
                  exp_w = exp_inst_q.pop_front();
                  chk("inst_resp", 69'(bus.Instruction), 69'(exp_w));
               end
            end
            if (bus.Read_data_Valid && bus.Read_data_Ready) begin
               rd_hs++;
               if (exp_rd_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rd_unexpected actual=%0h required=none", bus.Read_data);
               end else begin
                  exp_w = exp_rd_q.pop_front();
                  chk("rd_resp", 69'(bus.Read_data), 69'(exp_w));
               end
            end
            held_req_v  = bus.mem_req_valid && !bus.mem_req_ready;
            held_req    = cur_req;
            held_inst_v = bus.Inst_Valid && !bus.Inst_Ready;
            held_inst   = bus.Instruction;
            held_rd_v   = bus.Read_data_Valid && !bus.Read_data_Ready;
            held_rd     = bus.Read_data;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fetch(input logic [31:0] a);
      int t;
      t = 0;
      @(negedge clk);
      bus.PC = a;
      bus.Inst_Req_Valid = 1'b1;
      #2;
      while (!bus.Inst_Req_Ready && t < 200) begin
         @(negedge clk); #2; t++;
      end
      chk("fetch_grant", 69'(bus.Inst_Req_Ready), 69'd1);
      @(negedge clk);
      bus.Inst_Req_Valid = 1'b0;
      bus.PC = $urandom;
   endtask

   task automatic data_req(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [31:0] wd, input logic [3:0] ws);
      int t;
      t = 0;
      @(negedge clk);
      bus.Address = a; bus.MemRead = rd; bus.MemWrite = wr;
      bus.Write_data = wd; bus.Write_strb = ws;
      #2;
      while (!bus.Mem_Req_Ready && t < 200) begin
         @(negedge clk); #2; t++;
      end
      chk("data_grant", 69'(bus.Mem_Req_Ready), 69'd1);
      @(negedge clk);
      bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
      bus.Address = $urandom; bus.Write_data = $urandom;
      bus.Write_strb = 4'($urandom_range(0, 15));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_req_q.size() + exp_inst_q.size() + exp_rd_q.size()) != 0 && t < 500) begin
         @(negedge clk); t++;
      end
      repeat (2) @(negedge clk);
      chk("drain", 69'(exp_req_q.size() + exp_inst_q.size() + exp_rd_q.size()), 69'd0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int rd_before, mem_before;
      rst = 1'b1;
      bus.PC = '0; bus.Inst_Req_Valid = 1'b0;
      bus.Address = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
      bus.Write_data = '0; bus.Write_strb = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valids", 69'({bus.mem_req_valid, bus.mem_resp_ready, bus.Inst_Valid,
                             bus.Read_data_Valid, bus.Inst_Req_Ready, bus.Mem_Req_Ready}), 69'd0);
      chk("rst_req_fields", {bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb}, 69'd0);
      chk("rst_cpu_data", 69'({bus.Instruction, bus.Read_data}), 69'd0);
      chk("rst_cnt_state", 69'({conflict_cnt, fsm_state}), 69'd0);

      // Fetch read with cycle-exact latency.
      exp_req_q.push_back({32'h100, 1'b0, 32'h0, 4'h0});
      exp_inst_q.push_back(32'h3C08_0001);
      @(negedge clk);
      bus.PC = 32'h100; bus.Inst_Req_Valid = 1'b1;
      #1 chk("c0_inst_ready", 69'(bus.Inst_Req_Ready), 69'd1);
      @(negedge clk);
      bus.Inst_Req_Valid = 1'b0; bus.PC = $urandom;
      #1 chk("c1_req", 69'({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen}), 69'({1'b1, 32'h100, 1'b0}));
      @(negedge clk);
      #1 chk("c2_wait", 69'(fsm_state), 69'(ST_WAIT));
      @(negedge clk);
      #1 chk("c3_inst", 69'({bus.Inst_Valid, bus.Instruction}), 69'({1'b1, 32'h3C08_0001}));
      @(negedge clk);
      #1 chk("c4_idle", 69'(fsm_state), 69'(ST_IDLE));
      drain();

      // Store: one write beat, back in IDLE two cycles after grant.
      exp_req_q.push_back({32'h2004, 1'b1, 32'hDEAD_BEEF, 4'b0011});
      data_req(32'h2004, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011);
      #1 chk("st_c1_req", 69'({bus.mem_req_valid, fsm_state}), 69'({1'b1, ST_REQ}));
      @(negedge clk);
      #1 chk("st_c2_idle", 69'({bus.Read_data_Valid, fsm_state}), 69'({1'b0, ST_IDLE}));
      drain();

      // Conflict: data wins, fetch follows.
      exp_req_q.push_back({32'h3000, 1'b0, 32'h0, 4'h0});
      exp_req_q.push_back({32'h200, 1'b0, 32'h0, 4'h0});
      exp_rd_q.push_back(32'h1122_3344);
      exp_inst_q.push_back(32'h0000_AAAA);
      fork
         fetch(32'h200);
         data_req(32'h3000, 1'b1, 1'b0, 32'h5555_5555, 4'hF);
      join_none
      @(negedge clk);
      #1 chk("conf_readies", 69'({bus.Mem_Req_Ready, bus.Inst_Req_Ready}), 69'(2'b10));
      wait fork;
      drain();
      chk("conf_cnt", 69'(conflict_cnt), 69'd1);

      // Backpressure on both sides of a load.
      req_stall = 5; rd_hold = 3;
      rd_before = rd_hs; mem_before = mem_hs;
      exp_req_q.push_back({32'h3004, 1'b0, 32'h0, 4'h0});
      exp_rd_q.push_back(32'hCAFE_F00D);
      data_req(32'h3004, 1'b1, 1'b0, 32'h0, 4'h0);
      drain();
      chk("bp_mem_hs", 69'(mem_hs - mem_before), 69'd1);
      chk("bp_rd_hs", 69'(rd_hs - rd_before), 69'd1);
      req_stall = 0; rd_hold = 0;

      // Reset while waiting for a response; the late response must be ignored.
      auto_mem = 1'b0;
      exp_req_q.push_back({32'h104, 1'b0, 32'h0, 4'h0});
      fetch(32'h104);
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      #1 chk("rw_in_wait", 69'(fsm_state), 69'(ST_WAIT));
      rst = 1'b1;
      #1;
      chk("rw_state", 69'({fsm_state, bus.mem_resp_ready, bus.mem_req_valid, bus.Inst_Valid}), 69'd0);
      chk("rw_fields", 69'({bus.mem_req_addr, bus.Instruction}), 69'd0);
      chk("rw_cnt", 69'(conflict_cnt), 69'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h9999_9999;
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1 chk("rw_ignored", 69'({fsm_state, bus.Inst_Valid, bus.Instruction}), 69'd0);
      auto_mem = 1'b1;
      exp_req_q.push_back({32'h100, 1'b0, 32'h0, 4'h0});
      exp_inst_q.push_back(32'h3C08_0001);
      fetch(32'h100);
      drain();

      // MemRead and MemWrite together issue a write with no response.
      rd_before = rd_hs;
      exp_req_q.push_back({32'h2008, 1'b1, 32'h1234_5678, 4'b1111});
      data_req(32'h2008, 1'b1, 1'b1, 32'h1234_5678, 4'b1111);
      drain();
      repeat (3) @(negedge clk);
      chk("illegal_no_rd", 69'(rd_hs - rd_before), 69'd0);

      chk("total_mem_hs", 69'(mem_hs), 69'd8);
      chk("total_inst_hs", 69'(inst_hs), 69'd3);
      chk("total_rd_hs", 69'(rd_hs), 69'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
